// File: rtl/serial_adder_ctrl_pkg.sv
// serial_add_pkg: shared FSM encoding, default width and counter sizing for the bit-serial adder.
// Contents: state_e (IDLE/RUN/DONE), DEF_WIDTH, cnt_w(width) -> bit counter width.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle of the bit-serial adder.
// Ports: start_valid/start_ready + a_in/b_in/cin (operands), done_valid/done_ready + sum_out/cout (result),
// busy, ovf (only with SERIAL_ADD_OVF_EN). slave = controller side, master = requester side.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8) ();
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif
  modport slave (
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    input start_valid, a_in, b_in, cin, done_ready,
    output start_ready, sum_out, cout, done_valid, busy
  );
  modport master (
`ifdef SERIAL_ADD_OVF_EN
    input ovf,
`endif
    output start_valid, a_in, b_in, cin, done_ready,
    input start_ready, sum_out, cout, done_valid, busy
  );
endinterface

// File: rtl/serial_adder_ctrl_fulladder.sv
// fulladder: combinational 1-bit full-adder cell.
// Ports: a_i, b_i, c_i (addend bits, carry in) -> sum_o, carry_o.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller, LSB first, one bit per clock through one fulladder.
// Ports: clk, rst_n (async active-low), bus (serial_adder_ctrl_if.slave: operand and result handshakes).
// Optional: SERIAL_ADD_OVF_EN adds the signed-overflow result bit ovf.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
  assign bus.ovf = ovf_q;
`endif
  fulladder u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(carry_q), .sum_o(fa_s), .carry_o(fa_c));
  assign bus.start_ready = state_q == IDLE;
  assign bus.done_valid  = state_q == DONE;
  assign bus.busy        = state_q != IDLE;
  assign bus.sum_out     = sum_q;
  assign bus.cout        = cout_q;
  // Result registers are separate from the shift register so the last result survives the next accept.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start_valid) begin
        a_d     = bus.a_in;
        b_d     = bus.b_in;
        carry_d = bus.cin;
        cnt_d   = '0;
        sr_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sr_d    = {fa_s, sr_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sr_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on the last bit
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      DONE: state_d = bus.done_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule
